// File: rtl/jtframe_mc2_joy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtframe_mc2_joy                                              |
// | Description : Multi-port DB9 joystick scanner for Atari sticks and Mega    |
// |               Drive 3/6-button pads sharing one select line (pin 7).       |
// |               An idle gap with select high is followed by eight select     |
// |               steps. Per-port shadows collect the sampled buttons, and     |
// |               all ports are copied to the outputs together at scan end.    |
// | Ports       : clk_sys, rst            - clock, synchronous active-high rst |
// |               joy_*_i [NPORTS]        - raw active-low DB9 pins            |
// |               joyX_p7_o               - shared select line                 |
// |               joy_o [12*NPORTS]       - decoded active-high buttons        |
// |               pad6_o / md_o [NPORTS]  - pad type found in the last scan    |
// |               scan_done               - one-cycle pulse on output update   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtframe_mc2_joy #(
  parameter int NPORTS   = 2,
  parameter int STEP_LEN = 480,
  parameter int SCAN_GAP = 96000
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     joy_up_i,
  input  logic [NPORTS-1:0]     joy_down_i,
  input  logic [NPORTS-1:0]     joy_left_i,
  input  logic [NPORTS-1:0]     joy_right_i,
  input  logic [NPORTS-1:0]     joy_p6_i,
  input  logic [NPORTS-1:0]     joy_p9_i,
  output logic                  joyX_p7_o,
  output logic [12*NPORTS-1:0]  joy_o,
  output logic [NPORTS-1:0]     pad6_o,
  output logic [NPORTS-1:0]     md_o,
  output logic                  scan_done
);

  localparam int SW = $clog2(STEP_LEN);
  localparam int GW = $clog2(SCAN_GAP);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SCAN_GAP - 1);

  // Pin index inside the synchroniser vector
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  // Button index inside a port's 12-bit slice
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_B     = 4;
  localparam int B_C     = 5;
  localparam int B_A     = 6;
  localparam int B_START = 7;
  localparam int B_Z     = 8;
  localparam int B_Y     = 9;
  localparam int B_X     = 10;
  localparam int B_MODE  = 11;

  // Atari sticks only expose directions, fire (p6) and second button (p9)
  localparam logic [11:0] ATARI_MASK = 12'h03F;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  logic [5:0][NPORTS-1:0]  pin_raw;
  logic [5:0][NPORTS-1:0]  pin_meta_q, pin_meta_d;
  logic [5:0][NPORTS-1:0]  pin_sync_q, pin_sync_d;

  state_t                  state_q, state_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [SW-1:0]           cnt_q, cnt_d;
  logic [2:0]              step_q, step_d;

  logic [NPORTS-1:0]       md_sh_q, md_sh_d;
  logic [NPORTS-1:0]       six_sh_q, six_sh_d;
  logic [NPORTS-1:0][11:0] btn_sh_q, btn_sh_d;

  logic [12*NPORTS-1:0]    joy_q, joy_d;
  logic [NPORTS-1:0]       pad6_q, pad6_d;
  logic [NPORTS-1:0]       md_q, md_d;
  logic                    done_q, done_d;

  assign pin_raw = {joy_p9_i, joy_p6_i, joy_right_i, joy_left_i, joy_down_i, joy_up_i};

  always_comb begin
    pin_meta_d = pin_raw;
    pin_sync_d = pin_meta_q;
    state_d    = state_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    md_sh_d    = md_sh_q;
    six_sh_d   = six_sh_q;
    btn_sh_d   = btn_sh_q;
    joy_d      = joy_q;
    pad6_d     = pad6_q;
    md_d       = md_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_SCAN;
          gap_d   = '0;
          step_d  = 3'd0;
          cnt_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      ST_SCAN: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          for (int p = 0; p < NPORTS; p++) begin
            case (step_q)
              // First select-low phase: a Mega Drive pad pulls left/right low
              3'd0: begin
                md_sh_d[p]         = ~pin_sync_q[PIN_LEFT][p] & ~pin_sync_q[PIN_RIGHT][p];
                btn_sh_d[p][B_A]     = ~pin_sync_q[PIN_P6][p];
                btn_sh_d[p][B_START] = ~pin_sync_q[PIN_P9][p];
              end
              3'd1: begin
                btn_sh_d[p][B_UP]    = ~pin_sync_q[PIN_UP][p];
                btn_sh_d[p][B_DOWN]  = ~pin_sync_q[PIN_DOWN][p];
                btn_sh_d[p][B_LEFT]  = ~pin_sync_q[PIN_LEFT][p];
                btn_sh_d[p][B_RIGHT] = ~pin_sync_q[PIN_RIGHT][p];
                btn_sh_d[p][B_B]     = ~pin_sync_q[PIN_P6][p];
                btn_sh_d[p][B_C]     = ~pin_sync_q[PIN_P9][p];
              end
              // Third select-low phase: a 6-button pad drives all directions low
              3'd4: begin
                six_sh_d[p] = md_sh_q[p] & ~pin_sync_q[PIN_UP][p] & ~pin_sync_q[PIN_DOWN][p]
                            & ~pin_sync_q[PIN_LEFT][p] & ~pin_sync_q[PIN_RIGHT][p];
              end
              // Following high phase carries the extra buttons on the direction pins
              3'd5: begin
                btn_sh_d[p][B_Z]    = six_sh_q[p] & ~pin_sync_q[PIN_UP][p];
                btn_sh_d[p][B_Y]    = six_sh_q[p] & ~pin_sync_q[PIN_DOWN][p];
                btn_sh_d[p][B_X]    = six_sh_q[p] & ~pin_sync_q[PIN_LEFT][p];
                btn_sh_d[p][B_MODE] = six_sh_q[p] & ~pin_sync_q[PIN_RIGHT][p];
              end
              default: begin
              end
            endcase
          end

          if (step_q == 3'd7) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            done_d  = 1'b1;
            for (int p = 0; p < NPORTS; p++) begin
              joy_d[12*p +: 12] = md_sh_q[p] ? btn_sh_q[p] : (btn_sh_q[p] & ATARI_MASK);
              pad6_d[p]         = six_sh_q[p];
              md_d[p]           = md_sh_q[p];
            end
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pin_meta_q <= '1;
      pin_sync_q <= '1;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      md_sh_q    <= '0;
      six_sh_q   <= '0;
      btn_sh_q   <= '0;
      joy_q      <= '0;
      pad6_q     <= '0;
      md_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      pin_meta_q <= pin_meta_d;
      pin_sync_q <= pin_sync_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      md_sh_q    <= md_sh_d;
      six_sh_q   <= six_sh_d;
      btn_sh_q   <= btn_sh_d;
      joy_q      <= joy_d;
      pad6_q     <= pad6_d;
      md_q       <= md_d;
      done_q     <= done_d;
    end
  end

  // Select idles high; during the scan it is low on even steps
  assign joyX_p7_o = (state_q == ST_IDLE) | step_q[0];
  assign joy_o     = joy_q;
  assign pad6_o    = pad6_q;
  assign md_o      = md_q;
  assign scan_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_mc2_joy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtframe_mc2_joy                                           |
// | Description : Testbench for jtframe_mc2_joy. Two emulated pads (Atari,     |
// |               3-button or 6-button) answer the select line; decoded        |
// |               buttons are compared to the pressed set masked by pad type.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtframe_mc2_joy;

  localparam int NPORTS   = 2;
  localparam int STEP_LEN = 4;
  localparam int SCAN_GAP = 8;
  localparam int PERIOD   = SCAN_GAP + 8 * STEP_LEN;

  localparam logic [1:0] T_ATARI = 2'd0;
  localparam logic [1:0] T_THREE = 2'd1;
  localparam logic [1:0] T_SIX   = 2'd2;

  logic                 clk_sys = 1'b0;
  logic                 rst = 1'b1;
  logic [NPORTS-1:0]    joy_up_i, joy_down_i, joy_left_i, joy_right_i, joy_p6_i, joy_p9_i;
  logic                 joyX_p7_o;
  logic [12*NPORTS-1:0] joy_o;
  logic [NPORTS-1:0]    pad6_o, md_o;
  logic                 scan_done;

  // Pad configuration: type and pressed buttons in output bit order
  logic [1:0]  pad_type [NPORTS];
  logic [11:0] pad_btn  [NPORTS];

  int tests_run    = 0;
  int tests_failed = 0;

  jtframe_mc2_joy #(
    .NPORTS   (NPORTS),
    .STEP_LEN (STEP_LEN),
    .SCAN_GAP (SCAN_GAP)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .joy_up_i    (joy_up_i),
    .joy_down_i  (joy_down_i),
    .joy_left_i  (joy_left_i),
    .joy_right_i (joy_right_i),
    .joy_p6_i    (joy_p6_i),
    .joy_p9_i    (joy_p9_i),
    .joyX_p7_o   (joyX_p7_o),
    .joy_o       (joy_o),
    .pad6_o      (pad6_o),
    .md_o        (md_o),
    .scan_done   (scan_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad-side select counter: counts select falling edges, cleared after a long high
  int   lows    = 0;
  int   hi_run  = 0;
  logic p7_prev = 1'b1;

  always @(posedge clk_sys) begin
    if (joyX_p7_o) hi_run <= hi_run + 1;
    else           hi_run <= 0;
    if (!joyX_p7_o && p7_prev) lows <= lows + 1;
    else if (hi_run > 6)       lows <= 0;
    p7_prev <= joyX_p7_o;
  end

  // Pin levels a pad presents; result order {p9,p6,right,left,down,up}, active-low
  function automatic logic [5:0] pad_pins(input logic [1:0] typ, input logic [11:0] b,
                                          input logic sel, input int n_lows);
    logic [5:0] pr;
    pr = {b[5], b[4], b[0], b[1], b[2], b[3]};
    if (typ != T_ATARI && !sel) begin
      if (typ == T_SIX && n_lows == 3)      pr = {b[7], b[6], 4'b1111};
      else if (typ == T_SIX && n_lows == 4) pr = {b[7], b[6], 4'b0000};
      else                                  pr = {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
    end else if (typ == T_SIX && sel && n_lows == 3) begin
      pr = {b[5], b[4], b[11], b[10], b[9], b[8]};
    end
    return ~pr;
  endfunction

  for (genvar p = 0; p < NPORTS; p++) begin : g_pad
    logic [5:0] pins;
    assign pins           = pad_pins(pad_type[p], pad_btn[p], joyX_p7_o, lows);
    assign joy_up_i[p]    = pins[0];
    assign joy_down_i[p]  = pins[1];
    assign joy_left_i[p]  = pins[2];
    assign joy_right_i[p] = pins[3];
    assign joy_p6_i[p]    = pins[4];
    assign joy_p9_i[p]    = pins[5];
  end

  // Reference model: what each pad type can report
  function automatic logic [11:0] exp_joy(input logic [1:0] typ, input logic [11:0] b);
    case (typ)
      T_ATARI: return b & 12'h03F;
      T_THREE: return b & 12'h0FF;
      default: return b;
    endcase
  endfunction

  function automatic logic [23:0] exp_all();
    return {exp_joy(pad_type[1], pad_btn[1]), exp_joy(pad_type[0], pad_btn[0])};
  endfunction

  function automatic logic [1:0] exp_md();
    return {pad_type[1] != T_ATARI, pad_type[0] != T_ATARI};
  endfunction

  function automatic logic [1:0] exp_six();
    return {pad_type[1] == T_SIX, pad_type[0] == T_SIX};
  endfunction

  // Select level k cycles after the start of an idle gap
  function automatic logic exp_p7(input int k);
    int r;
    r = k % PERIOD;
    if (r < SCAN_GAP) return 1'b1;
    return ((r - SCAN_GAP) / STEP_LEN) % 2 == 1;
  endfunction

  // Physically a stick cannot press opposite directions together
  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[2] = 1'b0;
    return b;
  endfunction

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk_sys);
      if (scan_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_done: scan_done stayed 0 for %0d cycles, required a pulse", 4 * PERIOD);
    end
  endtask

  task automatic test_reset();
    pad_type[0] = T_SIX;   pad_btn[0] = 12'hFF5;
    pad_type[1] = T_THREE; pad_btn[1] = 12'h0F9;
    rst = 1'b1;
    repeat (4) @(negedge clk_sys);
    tests_run++;
    if (joyX_p7_o !== 1'b1) begin tests_failed++; $display("FAIL reset_p7: got %b, required 1", joyX_p7_o); end
    tests_run++;
    if (joy_o !== 24'h0) begin tests_failed++; $display("FAIL reset_joy: got %h, required 000000", joy_o); end
    tests_run++;
    if (pad6_o !== 2'b00) begin tests_failed++; $display("FAIL reset_pad6: got %b, required 00", pad6_o); end
    tests_run++;
    if (md_o !== 2'b00) begin tests_failed++; $display("FAIL reset_md: got %b, required 00", md_o); end
    tests_run++;
    if (scan_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, required 0", scan_done); end
  endtask

  // Releases reset and follows two full scan periods cycle by cycle
  task automatic test_timing();
    rst = 1'b0;
    for (int k = 0; k <= 2 * PERIOD; k++) begin
      tests_run++;
      if (joyX_p7_o !== exp_p7(k)) begin
        tests_failed++;
        $display("FAIL timing_p7 cycle %0d: got %b, required %b", k, joyX_p7_o, exp_p7(k));
      end
      tests_run++;
      if (scan_done !== (k > 0 && k % PERIOD == 0)) begin
        tests_failed++;
        $display("FAIL timing_done cycle %0d: got %b, required %b", k, scan_done, (k > 0 && k % PERIOD == 0));
      end
      if (k < 2 * PERIOD) @(negedge clk_sys);
    end
    tests_run++;
    if (joy_o !== exp_all()) begin tests_failed++; $display("FAIL timing_joy: got %h, required %h", joy_o, exp_all()); end
  endtask

  task automatic test_pad_types();
    logic [23:0] held;
    pad_type[0] = T_SIX;   pad_btn[0] = 12'h448;
    pad_type[1] = T_THREE; pad_btn[1] = 12'h0A0;
    wait_done();
    wait_done();
    tests_run++;
    if (joy_o[11:0] !== 12'h448) begin tests_failed++; $display("FAIL six_joy: got %h, required 448", joy_o[11:0]); end
    tests_run++;
    if (joy_o[23:12] !== 12'h0A0) begin tests_failed++; $display("FAIL three_joy: got %h, required 0a0", joy_o[23:12]); end
    tests_run++;
    if (pad6_o !== 2'b01) begin tests_failed++; $display("FAIL pad_types_pad6: got %b, required 01", pad6_o); end
    tests_run++;
    if (md_o !== 2'b11) begin tests_failed++; $display("FAIL pad_types_md: got %b, required 11", md_o); end
    held = joy_o;
    @(negedge clk_sys);
    tests_run++;
    if (scan_done !== 1'b0) begin tests_failed++; $display("FAIL done_width: got %b, required 0", scan_done); end
    pad_btn[0] = 12'h011;
    repeat (20) @(negedge clk_sys);
    tests_run++;
    if (joy_o !== held) begin tests_failed++; $display("FAIL hold: got %h, required %h", joy_o, held); end
  endtask

  task automatic test_atari();
    pad_type[0] = T_ATARI; pad_btn[0] = 12'h000;
    wait_done();
    wait_done();
    tests_run++;
    if (joy_o[11:0] !== 12'h000) begin tests_failed++; $display("FAIL atari_idle_joy: got %h, required 000", joy_o[11:0]); end
    tests_run++;
    if (md_o[0] !== 1'b0) begin tests_failed++; $display("FAIL atari_idle_md: got %b, required 0", md_o[0]); end
    pad_btn[0] = 12'h010;
    wait_done();
    wait_done();
    tests_run++;
    if (joy_o[11:0] !== 12'h010) begin tests_failed++; $display("FAIL atari_fire_joy: got %h, required 010", joy_o[11:0]); end
    tests_run++;
    if (md_o[0] !== 1'b0 || pad6_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL atari_fire_type: got md=%b pad6=%b, required md=0 pad6=0", md_o[0], pad6_o[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      for (int p = 0; p < NPORTS; p++) begin
        pad_type[p] = 2'($urandom_range(0, 2));
        pad_btn[p]  = rand_btn();
      end
      wait_done();
      wait_done();
      tests_run++;
      if (joy_o !== exp_all()) begin
        tests_failed++;
        $display("FAIL random_joy it %0d: got %h, required %h (types %0d/%0d)", it, joy_o, exp_all(), pad_type[0], pad_type[1]);
      end
      tests_run++;
      if (md_o !== exp_md()) begin tests_failed++; $display("FAIL random_md it %0d: got %b, required %b", it, md_o, exp_md()); end
      tests_run++;
      if (pad6_o !== exp_six()) begin tests_failed++; $display("FAIL random_pad6 it %0d: got %b, required %b", it, pad6_o, exp_six()); end
    end
  endtask

  task automatic test_reset_mid();
    pad_type[0] = T_SIX;   pad_btn[0] = 12'hA5A;
    pad_type[1] = T_THREE; pad_btn[1] = 12'h0C6;
    wait_done();
    wait_done();
    // Step 3 spans cycles SCAN_GAP+12 .. SCAN_GAP+15 after the done cycle
    repeat (SCAN_GAP + 3 * STEP_LEN + 1) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    tests_run++;
    if (joyX_p7_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_p7: got %b, required 1", joyX_p7_o); end
    tests_run++;
    if (joy_o !== 24'h0 || pad6_o !== 2'b00 || md_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got joy=%h pad6=%b md=%b, required all 0", joy_o, pad6_o, md_o);
    end
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    for (int k = 0; k <= PERIOD; k++) begin
      tests_run++;
      if (scan_done !== (k == PERIOD) || joyX_p7_o !== exp_p7(k)) begin
        tests_failed++;
        $display("FAIL midrst_scan cycle %0d: got done=%b p7=%b, required done=%b p7=%b",
                 k, scan_done, joyX_p7_o, (k == PERIOD), exp_p7(k));
      end
      if (k < PERIOD) begin
        tests_run++;
        if (joy_o !== 24'h0) begin tests_failed++; $display("FAIL midrst_hold cycle %0d: got %h, required 000000", k, joy_o); end
        @(negedge clk_sys);
      end
    end
    tests_run++;
    if (joy_o !== exp_all()) begin tests_failed++; $display("FAIL midrst_joy: got %h, required %h", joy_o, exp_all()); end
  endtask

  task automatic test_step6_change();
    logic [23:0] old_exp;
    pad_type[0] = T_SIX;   pad_btn[0] = 12'h448;
    pad_type[1] = T_THREE; pad_btn[1] = 12'h0A0;
    wait_done();
    wait_done();
    old_exp = exp_all();
    // Step 6 spans cycles SCAN_GAP+24 .. SCAN_GAP+27 after the done cycle
    repeat (SCAN_GAP + 6 * STEP_LEN + 1) @(negedge clk_sys);
    pad_btn[0] = 12'h905;
    pad_btn[1] = 12'h011;
    wait_done();
    tests_run++;
    if (joy_o !== old_exp) begin tests_failed++; $display("FAIL step6_same_scan: got %h, required %h", joy_o, old_exp); end
    wait_done();
    tests_run++;
    if (joy_o !== exp_all()) begin tests_failed++; $display("FAIL step6_next_scan: got %h, required %h", joy_o, exp_all()); end
  endtask

  initial begin
    pad_type[0] = T_ATARI; pad_btn[0] = 12'h000;
    pad_type[1] = T_ATARI; pad_btn[1] = 12'h000;
    test_reset();
    test_timing();
    test_pad_types();
    test_atari();
    test_random();
    test_reset_mid();
    test_step6_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
